// File: rtl/vip_window_ctrl_if.sv
// Video timing stream into the window controller and the window strobe/position coming back out.
interface vip_window_ctrl_if;
    logic       per_frame_vsync;
    logic       per_frame_href;
    logic       per_frame_clken;
    logic       shift_clken;
    logic       win_valid;
    logic [9:0] win_col;
    logic [9:0] win_row;

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken,
        input  shift_clken, win_valid, win_col, win_row
    );

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken,
        output shift_clken, win_valid, win_col, win_row
    );
endinterface

// File: rtl/vip_window_ctrl.sv
// Frame sequencer for a 3x3 window generator: gates the line-buffer shift, tracks pixel
// position, flags malformed lines/frames and reports window centres with the generator latency.
module vip_window_ctrl #(
    parameter logic [9:0] IMG_HDISP = 10'd480,
    parameter logic [9:0] IMG_VDISP = 10'd272
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable,
    vip_window_ctrl_if.slave   vid,
    output logic               frame_done,
    output logic               line_err,
    output logic               frame_err,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, ARMED, FRAME, DONE} state_t;

    state_t     state;
    state_t     state_nxt;
    logic       vsync_r;
    logic       href_r;
    logic       vsync_rise;
    logic       vsync_fall;
    logic       href_fall;
    logic       frame_start;
    logic       frame_end;
    logic [9:0] col;
    logic [9:0] row;
    logic [9:0] row_final;
    logic       qual;

    logic       vld_p0;
    logic [9:0] col_p0;
    logic [9:0] row_p0;
    logic       vld_p1;
    logic [9:0] col_p1;
    logic [9:0] row_p1;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    assign vsync_rise  = vid.per_frame_vsync & ~vsync_r;
    assign vsync_fall  = ~vid.per_frame_vsync & vsync_r;
    assign href_fall   = ~vid.per_frame_href & href_r;
    assign frame_start = (state == ARMED) && enable && vsync_rise;
    assign frame_end   = (state == FRAME) && vsync_fall;

    // A line closing in the same cycle as the frame still counts toward the frame length.
    assign row_final   = href_fall ? sat_inc(row) : row;

    assign vid.shift_clken = vid.per_frame_clken & vid.per_frame_href & (state == FRAME);
    assign frame_done      = (state == DONE);
    assign busy            = (state == ARMED) || (state == FRAME);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            vsync_r <= 1'b0;
            href_r  <= 1'b0;
        end else begin
            state   <= state_nxt;
            vsync_r <= vid.per_frame_vsync;
            href_r  <= vid.per_frame_href;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = ARMED;
            ARMED: begin
                if (!enable)         state_nxt = IDLE;
                else if (vsync_rise) state_nxt = FRAME;
            end
            FRAME:   if (vsync_fall) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col <= 10'd0;
            row <= 10'd0;
        end else if (frame_start) begin
            col <= 10'd0;
            row <= 10'd0;
        end else if (state == FRAME) begin
            if (href_fall) begin
                col <= 10'd0;
                row <= sat_inc(row);
            end else if (vid.shift_clken) begin
                col <= sat_inc(col);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            line_err  <= 1'b0;
            frame_err <= 1'b0;
        end else if (frame_start) begin
            line_err  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if ((state == FRAME) && href_fall && (col != IMG_HDISP)) line_err <= 1'b1;
            if (frame_end && (row_final != IMG_VDISP))               frame_err <= 1'b1;
        end
    end

    // Window centre lags the newest pixel by one row and one column.
    assign qual = vid.shift_clken && (row >= 10'd2) && (col >= 10'd2);

    // p0: capture qualifying pixel position
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p0 <= 1'b0;
            col_p0 <= 10'd0;
            row_p0 <= 10'd0;
        end else begin
            vld_p0 <= qual;
            if (qual) begin
                col_p0 <= col - 10'd1;
                row_p0 <= row - 10'd1;
            end
        end
    end

    // p1: aligned with generator output; position holds between valid windows
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1 <= 1'b0;
            col_p1 <= 10'd0;
            row_p1 <= 10'd0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                col_p1 <= col_p0;
                row_p1 <= row_p0;
            end
        end
    end

    assign vid.win_valid = vld_p1;
    assign vid.win_col   = col_p1;
    assign vid.win_row   = row_p1;

endmodule
